regfile_mp: RTL and testbench

Parametrised multi-port integer register file with a per-register busy scoreboard, the successor to the single-write, two-read register file in the npc core. It serves the issue and writeback stages of the pipeline, providing NUM_RD combinational read ports, NUM_WR prioritised write ports and busy tracking for in-flight destinations. Register 0 is hardwired to zero.

---
 rtl/regfile_mp.sv | 112 +++++++++++
 tb/tb_regfile_mp.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port integer register file with per-register busy scoreboard and pending count.
// Optional write-to-read forwarding is compiled in when REGFILE_BYPASS_EN is defined.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    localparam int AW    = $clog2(NREGS),
    localparam int PW    = $clog2(NREGS + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_RD*AW-1:0]     rd_addr_i,
    output logic [NUM_RD*XLEN-1:0]   rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*AW-1:0]     wr_addr_i,
    input  logic [NUM_WR*XLEN-1:0]   wr_data_i,
    input  logic                     iss_en_i,
    input  logic [AW-1:0]            iss_addr_i,
    output logic [PW-1:0]            pending_o
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] wr_hit;
    logic [NREGS-1:0] iss_hit;
    logic [NREGS-1:0] clr_vec;
    logic             set_inc;
    logic [PW-1:0]    clr_cnt;
    logic [PW-1:0]    pending_q;

    function automatic logic [PW-1:0] popcount(input logic [NREGS-1:0] v);
        logic [PW-1:0] cnt;
        cnt = '0;
        for (int r = 0; r < NREGS; r++) begin
            cnt = cnt + PW'(v[r]);
        end
        return cnt;
    endfunction

    // Decode which registers are written and issued this cycle; x0 never participates.
    always_comb begin
        wr_hit  = '0;
        iss_hit = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en_i[j]) begin
                wr_hit[wr_addr_i[j*AW +: AW]] = 1'b1;
            end
        end
        if (iss_en_i) begin
            iss_hit[iss_addr_i] = 1'b1;
        end
        wr_hit[0]  = 1'b0;
        iss_hit[0] = 1'b0;
        // A same-cycle issue supersedes the clear from the write.
        busy_d  = (busy_q & ~wr_hit) | iss_hit;
        set_inc = |(iss_hit & ~busy_q);
        clr_vec = busy_q & wr_hit & ~iss_hit;
        clr_cnt = popcount(clr_vec);
    end

    // Register array: ascending port loop lets the highest-index port win on collisions.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] != '0)) begin
                    regs_q[wr_addr_i[j*AW +: AW]] <= wr_data_i[j*XLEN +: XLEN];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q    <= '0;
            pending_q <= '0;
        end else begin
            busy_q    <= busy_d;
            pending_q <= pending_q + PW'(set_inc) - clr_cnt;
        end
    end

    assign pending_o = pending_q;

    // Read ports: stored state, optionally overridden by same-cycle writes.
    always_comb begin
        logic [AW-1:0] ra;
        ra        = '0;
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra = rd_addr_i[k*AW +: AW];
            rd_data_o[k*XLEN +: XLEN] = (ra == '0) ? '0 : regs_q[ra];
            rd_busy_o[k]              = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == ra) && (ra != '0)) begin
                    rd_data_o[k*XLEN +: XLEN] = wr_data_i[j*XLEN +: XLEN];
                    rd_busy_o[k]              = iss_en_i && (iss_addr_i == ra);
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus pushes expected outputs, a negedge monitor compares.
// Expectations follow REGFILE_BYPASS_EN when the bench is compiled with it.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int NUM_RD = 2;
    localparam int NUM_WR = 2;
    localparam int AW = 5;
    localparam int PW = 6;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_busy;
    logic [NUM_WR-1:0]      wr_en;
    logic [NUM_WR*AW-1:0]   wr_addr;
    logic [NUM_WR*XLEN-1:0] wr_data;
    logic                   iss_en;
    logic [AW-1:0]          iss_addr;
    logic [PW-1:0]          pending;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) dut (
        .clk_i(clk), .rst_i(rst),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .iss_en_i(iss_en), .iss_addr_i(iss_addr), .pending_o(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 data, 1 busy, 2 pending
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    bit          known = 0;
    bit [31:0]   m_regs [NREGS];
    bit          m_busy [NREGS];

    // Monitor: compare every queued expectation against the live outputs.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e = sb_q.pop_front();
            case (e.kind)
                0: act = rd_data[e.port*XLEN +: XLEN];
                1: act = {31'd0, rd_busy[e.port]};
                default: act = {26'd0, pending};
            endcase
            total++;
            if (act !== e.exp) begin
                bad++;
                $display("FAIL %s port%0d t=%0t got=%h want=%h",
                         (e.kind == 0) ? "rd_data" : (e.kind == 1) ? "rd_busy" : "pending_o",
                         e.port, $time, act, e.exp);
            end
        end
    end

    function automatic int m_pending();
        int c = 0;
        for (int r = 0; r < NREGS; r++) c += m_busy[r];
        return c;
    endfunction

    task automatic step(input bit r, input bit [1:0] we,
                        input bit [4:0] wa0, input bit [31:0] wd0,
                        input bit [4:0] wa1, input bit [31:0] wd1,
                        input bit ie, input bit [4:0] ia,
                        input bit [4:0] ra0, input bit [4:0] ra1);
        bit [4:0]  wa [2];
        bit [31:0] wd [2];
        bit [4:0]  ra [2];
        wa[0] = wa0; wa[1] = wa1; wd[0] = wd0; wd[1] = wd1; ra[0] = ra0; ra[1] = ra1;
        rst = r; wr_en = we; wr_addr = {wa1, wa0}; wr_data = {wd1, wd0};
        iss_en = ie; iss_addr = ia; rd_addr = {ra1, ra0};
        if (known) begin
            for (int k = 0; k < NUM_RD; k++) begin
                bit [31:0] ed;
                bit        eb;
                ed = (ra[k] == 0) ? 32'd0 : m_regs[ra[k]];
                eb = m_busy[ra[k]];
`ifdef REGFILE_BYPASS_EN
                for (int j = 0; j < NUM_WR; j++) begin
                    if (we[j] && wa[j] == ra[k] && ra[k] != 0) begin
                        ed = wd[j];
                        eb = ie && (ia == ra[k]);
                    end
                end
`endif
                sb_q.push_back('{0, k, ed});
                sb_q.push_back('{1, k, {31'd0, eb}});
            end
            sb_q.push_back('{2, 0, m_pending()});
        end
        @(posedge clk);
        #1;
        if (r) begin
            for (int i = 0; i < NREGS; i++) begin
                m_regs[i] = 0;
                m_busy[i] = 0;
            end
            known = 1;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (we[j] && wa[j] != 0) begin
                    m_regs[wa[j]] = wd[j];
                    m_busy[wa[j]] = 0;
                end
            end
            if (ie && ia != 0) m_busy[ia] = 1;
        end
    endtask

    function automatic bit [4:0] raddr();
        return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    endfunction

    initial begin
        rst = 1; wr_en = 0; wr_addr = 0; wr_data = 0; iss_en = 0; iss_addr = 0; rd_addr = 0;
        #2;
        step(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        // Reset clears a written register.
        step(0, 2'b01, 5, 32'hDEADBEEF, 0, 0, 1, 6, 5, 6);
        step(1, 2'b00, 0, 0, 0, 0, 0, 0, 5, 6);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 6);
        // Write collision on x7.
        step(0, 2'b11, 7, 32'h11111111, 7, 32'h22222222, 0, 0, 7, 7);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 7, 0);
        // x0 protection.
        step(0, 2'b01, 0, 32'hFFFFFFFF, 0, 0, 1, 0, 0, 0);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        // Scoreboard issue / clear.
        step(0, 2'b00, 0, 0, 0, 0, 1, 3, 3, 4);
        step(0, 2'b00, 0, 0, 0, 0, 1, 4, 3, 4);
        step(0, 2'b01, 3, 32'h33, 0, 0, 0, 0, 3, 4);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 4);
        // Issue/write clash on x9.
        step(0, 2'b01, 9, 32'hA5A5A5A5, 0, 0, 1, 9, 9, 4);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 4);
        // Forwarding window on x12.
        step(0, 2'b10, 0, 0, 12, 32'h12345678, 0, 0, 12, 12);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 12, 12);
        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 99) == 0),
                 2'($urandom_range(0, 3)),
                 raddr(), $urandom(), raddr(), $urandom(),
                 ($urandom_range(0, 2) == 0), raddr(),
                 raddr(), raddr());
        end
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got=%0d want=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
